// File: rtl/ah_pl2ddr_mc_burst_sched.sv
// Round-robin AXI write-burst scheduler: NUM_CH channel buffers into per-channel DDR ring regions.
// Optional flush of partial bursts is compiled in with `define AH_PL2DDR_FLUSH_EN.
module ah_pl2ddr_mc_burst_sched #(
    parameter int          NUM_CH         = 4,
    parameter int          CNT_WIDTH      = 10,
    parameter int          BURST_LEN      = 16,
    parameter int          BYTES_PER_BEAT = 4,
    parameter int          REGION_BITS    = 24,
    parameter logic [31:0] DDR_BASE       = 32'h00100000,
    localparam int         CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          m_axi_out_aclk,
    input  logic                          m_axi_out_aresetn,
    input  logic                          enable,
    input  logic [NUM_CH-1:0]             ch_enable,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   ch_avail,
    input  logic [NUM_CH-1:0]             ch_flush,
    input  logic [31:0]                   target_words,
    output logic                          tx_init,
    output logic [31:0]                   tx_addr,
    output logic [8:0]                    tx_len,
    output logic [CH_W-1:0]               tx_ch,
    input  logic                          tx_done,
    input  logic                          tx_error,
    output logic [NUM_CH-1:0]             ch_wrapped,
    output logic [NUM_CH-1:0]             ch_done,
    output logic                          all_done,
    output logic                          intr_done,
    output logic                          error,
    output logic                          busy,
    output logic [2:0]                    fsm_state,
    output logic [31:0]                   bursts_issued
);

    localparam int          BEAT_SH = $clog2(BYTES_PER_BEAT);
    localparam logic [31:0] BL      = 32'(BURST_LEN);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        SETTLE = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t                 state;
    logic [CH_W-1:0]        ptr;
    logic [REGION_BITS-1:0] offset  [NUM_CH];
    logic [31:0]            written [NUM_CH];
    logic                   all_done_q;

    logic [8:0]             len_c [NUM_CH];
    logic [NUM_CH-1:0]      elig;
    logic                   grant;
    logic [CH_W-1:0]        win;
    logic [8:0]             win_len;
    logic [REGION_BITS-1:0] win_off;
    logic [REGION_BITS-1:0] act_off;
    logic [REGION_BITS:0]   off_sum;

`ifdef AH_PL2DDR_FLUSH_EN
    logic [NUM_CH-1:0]      flush_pend;
`else
    logic                   unused_flush;
    assign unused_flush = ^ch_flush;
`endif

    // Per-channel burst length and eligibility, evaluated every cycle but consumed only in IDLE
    always_comb begin
        logic [31:0] off_w, room, room_4k, remain, avail;
        elig    = '0;
        off_w   = '0;
        room    = '0;
        room_4k = '0;
        remain  = '0;
        avail   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            off_w   = 32'(offset[c]);
            room    = BL - ((off_w >> BEAT_SH) & (BL - 32'd1));
            room_4k = (32'd4096 - (off_w & 32'h0000_0FFF)) >> BEAT_SH;
            if (room_4k < room)
                room = room_4k;
            remain  = target_words - written[c];
            if ((target_words != 32'd0) && (remain < room))
                room = remain;
            avail   = 32'(ch_avail[c*CNT_WIDTH +: CNT_WIDTH]);
            elig[c] = enable && ch_enable[c] && !ch_done[c] && (avail >= room);
`ifdef AH_PL2DDR_FLUSH_EN
            if (flush_pend[c]) begin
                if (avail < room)
                    room = avail;
                elig[c] = enable && ch_enable[c] && !ch_done[c] && (avail != 32'd0);
            end
`endif
            len_c[c] = room[8:0];
        end
    end

    // Round-robin: the eligible channel nearest after ptr (distance 0 = ptr+1) wins
    always_comb begin
        int best_d;
        int d;
        grant   = 1'b0;
        win     = '0;
        win_len = '0;
        win_off = '0;
        best_d  = NUM_CH;
        d       = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            d = c - int'(ptr) - 1;
            if (d < 0)
                d = d + NUM_CH;
            if (elig[c] && (d < best_d)) begin
                best_d  = d;
                grant   = 1'b1;
                win     = CH_W'(c);
                win_len = len_c[c];
                win_off = offset[c];
            end
        end
    end

    always_comb begin
        act_off = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (CH_W'(c) == tx_ch)
                act_off = offset[c];
    end

    assign off_sum = {1'b0, act_off} + (REGION_BITS+1)'(32'(tx_len) << BEAT_SH);

    always_comb begin
        for (int c = 0; c < NUM_CH; c++)
            ch_done[c] = (target_words != 32'd0) && (written[c] == target_words);
    end

    assign all_done  = (target_words != 32'd0) && ((ch_enable & ~ch_done) == '0) && (ch_enable != '0);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_ff @(posedge m_axi_out_aclk or negedge m_axi_out_aresetn) begin
        if (!m_axi_out_aresetn) begin
            state         <= IDLE;
            ptr           <= CH_W'(NUM_CH - 1);
            tx_init       <= 1'b0;
            tx_addr       <= '0;
            tx_len        <= '0;
            tx_ch         <= '0;
            error         <= 1'b0;
            bursts_issued <= '0;
            ch_wrapped    <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                offset[c]  <= '0;
                written[c] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        tx_ch   <= win;
                        tx_len  <= win_len;
                        tx_addr <= DDR_BASE + (32'(win) << REGION_BITS) + 32'(win_off);
                        ptr     <= win;
                        tx_init <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    tx_init       <= 1'b0;
                    bursts_issued <= bursts_issued + 32'd1;
                    state         <= WAIT;
                end
                WAIT: begin
                    // An error leaves offset/written untouched so the burst can be retried
                    if (tx_error) begin
                        error <= 1'b1;
                        state <= ERR;
                    end else if (tx_done) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (CH_W'(c) == tx_ch) begin
                                offset[c]  <= off_sum[REGION_BITS-1:0];
                                written[c] <= written[c] + 32'(tx_len);
                                if (off_sum[REGION_BITS])
                                    ch_wrapped[c] <= 1'b1;
                            end
                        end
                        state <= SETTLE;
                    end
                end
                SETTLE: state <= IDLE;
                ERR: begin
                    error <= 1'b1;
                    if (!enable)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge m_axi_out_aclk or negedge m_axi_out_aresetn) begin
        if (!m_axi_out_aresetn) begin
            all_done_q <= 1'b0;
            intr_done  <= 1'b0;
        end else begin
            all_done_q <= all_done;
            intr_done  <= all_done && !all_done_q;
        end
    end

`ifdef AH_PL2DDR_FLUSH_EN
    always_ff @(posedge m_axi_out_aclk or negedge m_axi_out_aresetn) begin
        if (!m_axi_out_aresetn) begin
            flush_pend <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_flush[c])
                    flush_pend[c] <= 1'b1;
                else if ((state == WAIT) && tx_done && !tx_error && (CH_W'(c) == tx_ch))
                    flush_pend[c] <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ah_pl2ddr_mc_burst_sched.sv
// Scoreboard bench for ah_pl2ddr_mc_burst_sched: a 4-channel instance and a 1-channel 4 KB-region instance.
module tb_ah_pl2ddr_mc_burst_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          total = 0;
    int          bad   = 0;
    int          intr_cnt = 0;
    bit          resp_en = 1'b1;
    bit          inj_err = 1'b0;

    // 4-channel instance
    logic        enable;
    logic [3:0]  ch_enable;
    logic [39:0] ch_avail;
    logic [3:0]  ch_flush;
    logic [31:0] target_words;
    logic        tx_init;
    logic [31:0] tx_addr;
    logic [8:0]  tx_len;
    logic [1:0]  tx_ch;
    logic        tx_done  = 1'b0;
    logic        tx_error = 1'b0;
    logic [3:0]  ch_wrapped, ch_done;
    logic        all_done, intr_done, error, busy;
    logic [2:0]  fsm_state;
    logic [31:0] bursts_issued;

    // 1-channel instance with 4 KB regions
    logic        enable_b;
    logic        tx_init_b;
    logic [31:0] tx_addr_b;
    logic [8:0]  tx_len_b;
    logic        tx_ch_b;
    logic        tx_done_b = 1'b0;
    logic        ch_wrapped_b, ch_done_b, all_done_b, intr_done_b, error_b, busy_b;
    logic [2:0]  fsm_state_b;
    logic [31:0] bursts_issued_b;

    ah_pl2ddr_mc_burst_sched dut (
        .m_axi_out_aclk(clk), .m_axi_out_aresetn(rst_n),
        .enable(enable), .ch_enable(ch_enable), .ch_avail(ch_avail), .ch_flush(ch_flush),
        .target_words(target_words), .tx_init(tx_init), .tx_addr(tx_addr), .tx_len(tx_len),
        .tx_ch(tx_ch), .tx_done(tx_done), .tx_error(tx_error), .ch_wrapped(ch_wrapped),
        .ch_done(ch_done), .all_done(all_done), .intr_done(intr_done), .error(error),
        .busy(busy), .fsm_state(fsm_state), .bursts_issued(bursts_issued)
    );

    ah_pl2ddr_mc_burst_sched #(.NUM_CH(1), .REGION_BITS(12)) dut_b (
        .m_axi_out_aclk(clk), .m_axi_out_aresetn(rst_n),
        .enable(enable_b), .ch_enable(1'b1), .ch_avail(10'd16), .ch_flush(1'b0),
        .target_words(32'd0), .tx_init(tx_init_b), .tx_addr(tx_addr_b), .tx_len(tx_len_b),
        .tx_ch(tx_ch_b), .tx_done(tx_done_b), .tx_error(1'b0), .ch_wrapped(ch_wrapped_b),
        .ch_done(ch_done_b), .all_done(all_done_b), .intr_done(intr_done_b), .error(error_b),
        .busy(busy_b), .fsm_state(fsm_state_b), .bursts_issued(bursts_issued_b)
    );

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] addr;
        logic [8:0]  len;
    } burst_t;

    burst_t      exp_q[$];
    logic [31:0] exp_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic burst_t mk(input logic [1:0] c, input logic [31:0] a, input logic [8:0] l);
        burst_t b;
        b.ch = c; b.addr = a; b.len = l;
        return b;
    endfunction

    // Monitors: every tx_init pops the next expected burst
    always @(negedge clk) begin
        burst_t e;
        if (rst_n && tx_init) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_burst: got ch=%0d addr=%0h len=%0d required none", tx_ch, tx_addr, tx_len);
            end else begin
                e = exp_q.pop_front();
                check("burst", 64'({tx_ch, tx_addr, tx_len}), 64'(e));
            end
        end
        if (intr_done) intr_cnt++;
    end

    always @(negedge clk) begin
        logic [31:0] ea;
        if (rst_n && tx_init_b) begin
            if (exp_b.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_burst_b: got addr=%0h required none", tx_addr_b);
            end else begin
                ea = exp_b.pop_front();
                check("burst_b", 64'({tx_ch_b, tx_addr_b, tx_len_b}), 64'({1'b0, ea, 9'd16}));
            end
        end
    end

    // AXI-master models: completion 3 cycles after tx_init
    always begin
        @(posedge clk); #1;
        if (rst_n && tx_init && resp_en) begin
            repeat (3) @(posedge clk);
            #1 tx_done = 1'b1; tx_error = inj_err;
            @(posedge clk);
            #1 tx_done = 1'b0; tx_error = 1'b0;
        end
    end

    always begin
        @(posedge clk); #1;
        if (rst_n && tx_init_b) begin
            repeat (3) @(posedge clk);
            #1 tx_done_b = 1'b1;
            @(posedge clk);
            #1 tx_done_b = 1'b0;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
        int i = 0;
        while (fsm_state !== s && i < budget) begin
            @(posedge clk); #1; i++;
        end
        check(nm, 64'(fsm_state), 64'(s));
    endtask

    task automatic wait_bursts(input int n, input int budget, input string nm);
        int i = 0;
        while (bursts_issued < 32'(n) && i < budget) begin
            @(posedge clk); #1; i++;
        end
        check(nm, 64'(bursts_issued), 64'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        int i;
        rst_n = 1'b0; enable = 1'b0; ch_enable = '0; ch_avail = '0; ch_flush = '0;
        target_words = '0; enable_b = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rst_ctrl", 64'({tx_init, busy, fsm_state, error, all_done, intr_done}), 64'd0);
        check("rst_tx", 64'({tx_ch, tx_len, tx_addr}), 64'd0);
        check("rst_bursts", 64'(bursts_issued), 64'd0);
        check("rst_flags", 64'({ch_wrapped, ch_done}), 64'd0);
        rst_n = 1'b1;

        // Round-robin over four full channels, unlimited target
        ch_avail = {4{10'd16}}; ch_enable = 4'hF;
        exp_q.push_back(mk(2'd0, 32'h0010_0000, 9'd16));
        exp_q.push_back(mk(2'd1, 32'h0110_0000, 9'd16));
        exp_q.push_back(mk(2'd2, 32'h0210_0000, 9'd16));
        exp_q.push_back(mk(2'd3, 32'h0310_0000, 9'd16));
        exp_q.push_back(mk(2'd0, 32'h0010_0040, 9'd16));
        enable = 1'b1;
        wait_bursts(5, 300, "rr_bursts");
        enable = 1'b0;
        wait_state(3'd0, 50, "rr_idle");
        check("rr_q_empty", 64'(exp_q.size()), 64'd0);
        check("rr_no_wrap", 64'(ch_wrapped), 64'd0);

        // Target of 40 words on one channel: 16, 16, 8 then done
        do_reset();
        target_words = 32'd40; ch_enable = 4'b0001; intr_cnt = 0;
        exp_q.push_back(mk(2'd0, 32'h0010_0000, 9'd16));
        exp_q.push_back(mk(2'd0, 32'h0010_0040, 9'd16));
        exp_q.push_back(mk(2'd0, 32'h0010_0080, 9'd8));
        enable = 1'b1;
        wait_bursts(3, 200, "tgt_bursts");
        repeat (30) @(posedge clk); #1;
        check("tgt_count", 64'(bursts_issued), 64'd3);
        check("tgt_ch_done", 64'(ch_done), 64'h1);
        check("tgt_all_done", 64'(all_done), 64'd1);
        check("tgt_intr_once", 64'(intr_cnt), 64'd1);
        check("tgt_idle", 64'(fsm_state), 64'd0);
        enable = 1'b0; target_words = 32'd0;

        // Simultaneous error and done: ERR, offset kept, error sticky until reset
        do_reset();
        inj_err = 1'b1;
        exp_q.push_back(mk(2'd0, 32'h0010_0000, 9'd16));
        enable = 1'b1;
        wait_state(3'd4, 100, "err_state");
        check("err_flag", 64'(error), 64'd1);
        check("err_busy", 64'(busy), 64'd1);
        repeat (3) @(posedge clk); #1;
        check("err_hold", 64'(fsm_state), 64'd4);
        enable = 1'b0; inj_err = 1'b0;
        wait_state(3'd0, 10, "err_exit");
        check("err_sticky", 64'(error), 64'd1);
        exp_q.push_back(mk(2'd0, 32'h0010_0000, 9'd16));
        enable = 1'b1;
        wait_bursts(2, 100, "err_retry");
        enable = 1'b0;
        wait_state(3'd0, 50, "err_retry_idle");
        do_reset();
        check("err_cleared", 64'(error), 64'd0);

        // Asynchronous reset in the middle of WAIT
        resp_en = 1'b0;
        exp_q.push_back(mk(2'd0, 32'h0010_0000, 9'd16));
        enable = 1'b1;
        wait_state(3'd2, 50, "ar_wait");
        check("ar_pre_count", 64'(bursts_issued), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_state", 64'({busy, fsm_state, tx_init}), 64'd0);
        check("ar_tx", 64'({tx_ch, tx_len, tx_addr}), 64'd0);
        check("ar_count", 64'(bursts_issued), 64'd0);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; resp_en = 1'b1;

`ifdef AH_PL2DDR_FLUSH_EN
        // Flush a 5-word partial burst, then realign with an 11-beat burst
        do_reset();
        ch_enable = 4'b0001; ch_avail = {30'd0, 10'd5};
        exp_q.push_back(mk(2'd0, 32'h0010_0000, 9'd5));
        exp_q.push_back(mk(2'd0, 32'h0010_0014, 9'd11));
        ch_flush = 4'b0001;
        @(posedge clk); #1 ch_flush = '0;
        enable = 1'b1;
        wait_bursts(1, 100, "fl_first");
        ch_avail = {30'd0, 10'd16};
        wait_bursts(2, 100, "fl_second");
        enable = 1'b0;
        wait_state(3'd0, 50, "fl_idle");
`endif

        // 4 KB region wraps after 64 bursts of 64 bytes
        for (int k = 0; k <= 64; k++)
            exp_b.push_back(32'h0010_0000 + 32'((k * 64) % 4096));
        enable_b = 1'b1;
        i = 0;
        while (bursts_issued_b < 32'd64 && i < 2000) begin
            @(posedge clk); #1; i++;
        end
        check("wrap_not_yet", 64'(ch_wrapped_b), 64'd0);
        i = 0;
        while (bursts_issued_b < 32'd65 && i < 200) begin
            @(posedge clk); #1; i++;
        end
        check("wrap_bursts", 64'(bursts_issued_b), 64'd65);
        enable_b = 1'b0;
        i = 0;
        while (busy_b && i < 50) begin
            @(posedge clk); #1; i++;
        end
        check("wrap_flag", 64'(ch_wrapped_b), 64'd1);
        check("wrap_q_empty", 64'(exp_b.size()), 64'd0);
        check("final_q_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ah_pl2ddr_mc_burst_sched.md
Name: ah_pl2ddr_mc_burst_sched

Overview:
Multi-channel successor to the single-stream PL2DDR burst control. It schedules AXI write bursts from NUM_CH per-channel sample buffers into per-channel ring regions in DDR, using round-robin arbitration. It sits between the channel buffers (which report words available) and the AXI master (INIT_AXI_TXN/TXN_DONE-style handshake), and drives the data-mux select for the active burst.

Parameters:
NUM_CH, 4, number of channels (1..16)
CNT_WIDTH, 10, width of each per-channel words-available count
BURST_LEN, 16, maximum beats per burst (power of 2, 1..256)
BYTES_PER_BEAT, 4, bytes per AXI beat (power of 2)
REGION_BITS, 24, log2 of the per-channel region size in bytes; must be >= 12
DDR_BASE, 32'h00100000, base address of channel 0's region

Ports:
m_axi_out_aclk  in  1  clock
m_axi_out_aresetn  in  1  asynchronous active-low reset
enable  in  1  global run; low = no new bursts
ch_enable  in  NUM_CH  per-channel participation
ch_avail  in  NUM_CH*CNT_WIDTH  words available per channel; channel c at [c*CNT_WIDTH +: CNT_WIDTH]
ch_flush  in  NUM_CH  flush request pulse (optional feature only)
target_words  in  32  words per channel before done; 0 = unlimited
tx_init  out  1  one-cycle burst start pulse
tx_addr  out  32  burst start address
tx_len  out  9  burst beats (1..BURST_LEN)
tx_ch  out  CH_W=max(1,$clog2(NUM_CH))  active channel / data-mux select
tx_done  in  1  burst completion pulse
tx_error  in  1  burst error pulse
ch_wrapped  out  NUM_CH  sticky: region pointer wrapped
ch_done  out  NUM_CH  channel reached target_words
all_done  out  1  all enabled channels done (target != 0)
intr_done  out  1  one-cycle pulse on all_done rising edge
error  out  1  sticky error
busy  out  1  FSM not in IDLE
fsm_state  out  3  state encoding
bursts_issued  out  32  total tx_init count

Behaviour:
- Async reset values: all outputs 0; FSM = IDLE; round-robin pointer = NUM_CH-1; per-channel offset and written counters = 0.
- Region of channel c: DDR_BASE + c<<REGION_BITS. tx_addr = base + offset[c]. Offsets advance modulo 2^REGION_BITS.
- Length computation in IDLE:
  - room = BURST_LEN - ((offset/BYTES_PER_BEAT) mod BURST_LEN), the beats left to the burst-aligned boundary.
  - len = min(room, target_words - written[c]) when target_words != 0; otherwise len = room.
  - No burst ever crosses a 4 KB boundary.
- Eligibility: enable && ch_enable[c] && !ch_done[c] && ch_avail[c] >= len.
- Arbitration: search starts at pointer+1 and wraps; the first eligible channel wins. Grant latches tx_ch, tx_addr, tx_len, then the pointer is set to the winner.
- FSM, encodings 0..4:
  - IDLE(0): on a grant -> ISSUE.
  - ISSUE(1): tx_init=1 for exactly one cycle; bursts_issued++ -> WAIT.
  - WAIT(2): on tx_error -> ERR, with no pointer or counter update; tx_error wins over a simultaneous tx_done. On tx_done -> offset[c] += len*BYTES_PER_BEAT; written[c] += len; set ch_wrapped[c] if the offset overflowed the region -> SETTLE.
  - SETTLE(3): one cycle so ch_avail reflects the pops -> IDLE.
  - ERR(4): error=1 (sticky until reset); stays in ERR while enable=1; -> IDLE when enable=0.
- tx_addr, tx_len and tx_ch are held stable from ISSUE through SETTLE.
- Deasserting enable or ch_enable mid-burst does not abort the burst; both are sampled only in IDLE.
- ch_done[c] is set when target_words != 0 and written[c] == target_words.
- all_done = (target_words != 0) && (ch_enable & ~ch_done) == 0 && ch_enable != 0.
- Changing target_words while busy is undefined; software changes it only while idle.
- Counter widths: written is 32 bits, offset is REGION_BITS bits, bursts_issued is 32 bits and wraps silently.

Optional Feature:
- Macro: AH_PL2DDR_FLUSH_EN.
- Defined: a ch_flush[c] pulse sets a pending flag. While the flag is set, channel c is eligible with ch_avail[c] > 0 and issues len = min(len, ch_avail[c]). The flag clears on that channel's tx_done. Offsets may then be off-boundary; the room term realigns subsequent bursts.
- Undefined: ch_flush is ignored and no flag registers are built; only full len bursts are issued.

Test Plan:
- NUM_CH=4, all ch_avail=16, target_words=0, tx_done 3 cycles after tx_init -> grants 0,1,2,3,0; tx_addr 0x00100000, 0x01100000, 0x02100000, 0x03100000, then 0x00100040; tx_len=16.
- REGION_BITS=12, ch0 only, avail held at 16 -> after 64 bursts tx_addr returns to 0x00100000 and ch_wrapped[0]=1.
- target_words=40, one channel -> tx_len 16, 16, 8; then ch_done=1, all_done=1, one intr_done pulse, no further tx_init.
- tx_error and tx_done in the same WAIT cycle -> ERR, error=1, offset unchanged; enable=0 -> IDLE with error still 1; reset -> error=0.
- Reset asserted during WAIT -> all outputs 0 immediately, FSM IDLE, bursts_issued=0.
- With AH_PL2DDR_FLUSH_EN: ch0 avail=5, ch_flush[0] pulse -> tx_len=5; next burst at offset 20 has tx_len=11 (room) when avail >= 11.
